// File: rtl/uart_tx.sv
// 8N1 UART transmitter that pulls bytes from a registered-output FIFO.
// One frame per pop: IDLE -> FETCH -> START -> DATA x8 -> STOP -> IDLE.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic [7:0] fifo_rdata,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // Gated by rst_n so no pop can be requested while the block is held in reset.
    assign fifo_rd = rst_n & (state_q == IDLE) & tx_en & ~fifo_empty;
    assign busy    = (state_q != IDLE);
    assign tx      = tx_q;
    assign tx_done = done_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = 3'd0;
                if (fifo_rd) state_d = FETCH;
            end
            FETCH: begin
                // FIFO data is valid now, one cycle after the pop.
                shift_d = fifo_rdata;
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                bit_d   = 3'd0;
                state_d = IDLE;
            end
        endcase
    end

    // tx resets high asynchronously so an aborted frame releases the line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: FIFO model, line decoder with frame-level reference,
// directed scenarios followed by a randomized run.
module tb_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       tx_done;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_mem[$];
  logic [7:0] exp_q[$];
  logic       hold_empty;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int mon_cyc = 0;
  logic mon_active = 1'b0;
  logic [9:0] mon_frame;
  logic [7:0] mon_byte;
  logic [7:0] last_byte = 8'h00;
  int end_cyc = 0;
  int done_cyc = -1;
  int last_rd_cyc = -100;
  int last_gap = 0;
  logic prev_rd = 1'b0;
  logic rd_seen = 1'b0;
  logic busy_exp;
  int frames = 0;
  int frames0 = 0;
  int rd_cnt, busy_cnt, done_cnt, tx_low_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = hold_empty || (fifo_mem.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem.push_back(b);
    upd_empty();
  endtask

  task automatic clr_cnt();
    rd_cnt = 0; busy_cnt = 0; done_cnt = 0; tx_low_cnt = 0; frames0 = frames;
  endtask

  // One clock: observe/check at negedge, then model the FIFO just after posedge.
  task automatic step();
    logic [7:0] b;
    @(negedge clk);
    cyc++;
    rd_seen = 1'b0;
    if (!rst_n) begin
      mon_active = 1'b0;
      prev_rd = 1'b0;
      exp_q.delete();
      check_eq("rst_tx", 32'(tx), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(tx_done), 32'd0);
      check_eq("rst_rd", 32'(fifo_rd), 32'd0);
    end else begin
      if (!mon_active && tx == 1'b0) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_start", 32'd1, 32'd0);
        end else begin
          mon_byte = exp_q.pop_front();
          mon_frame = {1'b1, mon_byte, 1'b0};
          mon_active = 1'b1;
          mon_cyc = 0;
          check_eq("start_lat", 32'(cyc - last_rd_cyc), 32'd2);
          last_gap = cyc - end_cyc;
        end
      end
      busy_exp = mon_active || prev_rd;
      check_eq("busy", 32'(busy), 32'(busy_exp));
      check_eq("tx_done", 32'(tx_done), 32'(cyc == done_cyc));
      check_eq("fifo_rd", 32'(fifo_rd), 32'(!busy_exp && tx_en && !fifo_empty));
      if (mon_active) begin
        check_eq("tx_bit", 32'(tx), 32'(mon_frame[mon_cyc / CPB]));
        mon_cyc++;
        if (mon_cyc == 10 * CPB) begin
          mon_active = 1'b0;
          frames++;
          last_byte = mon_byte;
          end_cyc = cyc + 1;
          done_cyc = cyc + 1;
        end
      end else begin
        check_eq("tx_idle", 32'(tx), 32'd1);
      end
      rd_seen = fifo_rd;
      if (fifo_rd) begin
        last_rd_cyc = cyc;
        rd_cnt++;
      end
      prev_rd = fifo_rd;
      busy_cnt += int'(busy);
      done_cnt += int'(tx_done);
      tx_low_cnt += int'(!tx);
    end
    @(posedge clk);
    #1;
    if (rd_seen) begin
      if (fifo_mem.size() == 0) begin
        check_eq("pop_empty", 32'd1, 32'd0);
      end else begin
        b = fifo_mem.pop_front();
        fifo_rdata = b;
        exp_q.push_back(b);
      end
    end else begin
      fifo_rdata = 8'($urandom);
    end
    upd_empty();
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((fifo_mem.size() != 0 || exp_q.size() != 0 || mon_active || busy) && n < max_cyc) begin
      step();
      n++;
    end
    check_eq("drain_timeout", 32'(n < max_cyc), 32'd1);
    repeat (2) step();
  endtask

  task automatic wait_mon(input int target, input int max_cyc);
    int n = 0;
    while (!(mon_active && mon_cyc >= target) && n < max_cyc) begin
      step();
      n++;
    end
    check_eq("wait_timeout", 32'(n < max_cyc), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    tx_en = 1'b1;
    hold_empty = 1'b0;
    fifo_rdata = 8'h00;
    push(8'h11);
    clr_cnt();
    repeat (3) step();
    rst_n = 1'b1;
    drain(200);
    check_eq("first_byte", 32'(last_byte), 32'h11);

    // Empty FIFO with tx_en high: nothing happens.
    clr_cnt();
    repeat (100) step();
    check_eq("empty_rd", 32'(rd_cnt), 32'd0);
    check_eq("empty_busy", 32'(busy_cnt), 32'd0);
    check_eq("empty_txlow", 32'(tx_low_cnt), 32'd0);

    // Single byte 0xA5.
    clr_cnt();
    push(8'hA5);
    drain(200);
    check_eq("a5_rd", 32'(rd_cnt), 32'd1);
    check_eq("a5_done", 32'(done_cnt), 32'd1);
    check_eq("a5_busy", 32'(busy_cnt), 32'(1 + 10 * CPB));
    check_eq("a5_frames", 32'(frames - frames0), 32'd1);
    check_eq("a5_byte", 32'(last_byte), 32'hA5);

    // Back-to-back 0x00, 0xFF.
    clr_cnt();
    push(8'h00);
    push(8'hFF);
    drain(300);
    check_eq("b2b_rd", 32'(rd_cnt), 32'd2);
    check_eq("b2b_done", 32'(done_cnt), 32'd2);
    check_eq("b2b_gap", 32'(last_gap), 32'd2);
    check_eq("b2b_byte", 32'(last_byte), 32'hFF);

    // tx_en dropped during data bit 3; second byte must stay queued.
    clr_cnt();
    push(8'h3C);
    push(8'h55);
    wait_mon(4 * CPB + 1, 50);
    tx_en = 1'b0;
    repeat (80) step();
    check_eq("en_rd", 32'(rd_cnt), 32'd1);
    check_eq("en_byte", 32'(last_byte), 32'h3C);
    check_eq("en_frames", 32'(frames - frames0), 32'd1);
    check_eq("en_busy", 32'(busy), 32'd0);
    tx_en = 1'b1;
    drain(200);
    check_eq("en_resume", 32'(last_byte), 32'h55);

    // Reset during data bit 5, then 0x81 queued.
    clr_cnt();
    push(8'hC3);
    wait_mon(6 * CPB + 1, 50);
    fifo_mem.delete();
    push(8'h81);
    rst_n = 1'b0;
    #1;
    check_eq("arst_tx", 32'(tx), 32'd1);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_rd", 32'(fifo_rd), 32'd0);
    check_eq("arst_done", 32'(tx_done), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    drain(200);
    check_eq("rst_frames", 32'(frames - frames0), 32'd1);
    check_eq("rst_byte", 32'(last_byte), 32'h81);

    // fifo_empty raised in START: frame keeps the captured byte.
    clr_cnt();
    push(8'h69);
    push(8'h96);
    wait_mon(1, 50);
    hold_empty = 1'b1;
    upd_empty();
    begin
      int n = 0;
      while (mon_active && n < 100) begin step(); n++; end
      check_eq("hold_timeout", 32'(n < 100), 32'd1);
    end
    repeat (20) step();
    check_eq("hold_byte", 32'(last_byte), 32'h69);
    check_eq("hold_rd", 32'(rd_cnt), 32'd1);
    hold_empty = 1'b0;
    upd_empty();
    drain(200);
    check_eq("hold_resume", 32'(last_byte), 32'h96);

    // Randomized traffic.
    clr_cnt();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) push(8'($urandom));
      tx_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) hold_empty = ~hold_empty;
      upd_empty();
      step();
    end
    tx_en = 1'b1;
    hold_empty = 1'b0;
    upd_empty();
    drain(6000);
    check_eq("rand_pending", 32'(exp_q.size()), 32'd0);
    check_eq("rand_frames", 32'(frames - frames0), 32'(rd_cnt));
    check_eq("rand_done", 32'(done_cnt), 32'(rd_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
